// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared FSM state, reserved entry indices and default init values for reg_file_mp
package reg_file_pkg;
   typedef enum logic {INIT, IDLE} state_e;
   localparam int SP_IDX = 2;
   localparam int GP_IDX = 3;
   localparam logic [31:0] SP_INIT_DEF = 32'hF00;
   localparam logic [31:0] GP_INIT_DEF = 32'h100;
endpackage

// File: rtl/reg_file_rdport.sv
// reg_file_rdport: one combinational read port with zero masking and optional write bypass
module reg_file_rdport
   import reg_file_pkg::*;
#(
   parameter int DWIDTH = 32,
   parameter int MDEPTH = 32,
   parameter int AWIDTH = 5
)(
   input  logic              busy_i,
   input  logic              byp_i,
   input  logic [AWIDTH-1:0] ra_i,
   input  logic [AWIDTH-1:0] wa_i,
   input  logic [DWIDTH-1:0] wd_i,
   input  logic [DWIDTH-1:0] mem_i [MDEPTH],
   output logic [DWIDTH-1:0] rd_o
);
   // entry 0, out-of-range addresses and the init walk all read as zero
   always_comb
      rd_o = (busy_i || ra_i == '0 || {1'b0, ra_i} >= (AWIDTH+1)'(MDEPTH)) ? '0 :
             (byp_i && ra_i == wa_i) ? wd_i : mem_i[ra_i];
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with hardware init walk; define REG_FILE_MP_BYPASS_EN for same-cycle write-to-read bypass
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int DWIDTH = 32,
   parameter int MDEPTH = 32,
   parameter int AWIDTH = 5,
   parameter int NRD = 2,
   parameter logic [DWIDTH-1:0] SP_INIT = DWIDTH'(SP_INIT_DEF),
   parameter logic [DWIDTH-1:0] GP_INIT = DWIDTH'(GP_INIT_DEF)
)(
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  WE,
   input  logic [AWIDTH-1:0]     WA,
   input  logic [DWIDTH-1:0]     WD,
   input  logic                  CLR,
   input  logic [NRD*AWIDTH-1:0] RA,
   output logic [NRD*DWIDTH-1:0] RD,
   output logic                  INIT_BUSY,
   output logic                  WR_DROP
);
   state_e state_q, state_d;
   logic [AWIDTH-1:0] cnt_q, cnt_d;
   logic drop_q, drop_d;
   logic [DWIDTH-1:0] mem_q [MDEPTH];
   logic init, clr_acc, in_rng, wr_en, last, byp_en;
   logic [DWIDTH-1:0] init_val;

   // next state, walk counter, write qualification and drop detection
   always_comb begin
      init     = state_q == INIT;
      clr_acc  = !init && CLR;
      in_rng   = {1'b0, WA} < (AWIDTH+1)'(MDEPTH);
      wr_en    = WE && !init && !clr_acc && in_rng && WA != '0;
      drop_d   = WE && (init || clr_acc || !in_rng);
      last     = cnt_q == AWIDTH'(MDEPTH-1);
      state_d  = init ? (last ? IDLE : INIT) : (CLR ? INIT : IDLE);
      cnt_d    = (init && !last) ? cnt_q + 1'b1 : '0;
      init_val = (cnt_q == AWIDTH'(SP_IDX)) ? SP_INIT :
                 (cnt_q == AWIDTH'(GP_IDX)) ? GP_INIT : '0;
   end

`ifdef REG_FILE_MP_BYPASS_EN
   assign byp_en = wr_en;
`else
   assign byp_en = 1'b0;
`endif

   // control state; reset restarts the init walk from entry 0
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         state_q <= INIT;
         cnt_q   <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         drop_q  <= drop_d;
      end

   // storage is filled only by the init walk or accepted writes, never by reset
   always_ff @(posedge CLK)
      if (init) mem_q[cnt_q] <= init_val;
      else if (wr_en) mem_q[WA] <= WD;

   assign INIT_BUSY = init;
   assign WR_DROP   = drop_q;

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      reg_file_rdport #(.DWIDTH(DWIDTH), .MDEPTH(MDEPTH), .AWIDTH(AWIDTH)) u_rd (
         .busy_i (init),
         .byp_i  (byp_en),
         .ra_i   (RA[k*AWIDTH +: AWIDTH]),
         .wa_i   (WA),
         .wd_i   (WD),
         .mem_i  (mem_q),
         .rd_o   (RD[k*DWIDTH +: DWIDTH])
      );
   end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: scoreboard bench for reg_file_mp (init walk, writes, drops, bypass, soft clear, mid-init reset)
module tb_reg_file_mp;
   localparam int DW = 32, AW = 5, MD = 32, NR = 2;
`ifdef REG_FILE_MP_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   logic CLK = 1'b0, RST_N = 1'b0, WE = 1'b0, CLR = 1'b0;
   logic [AW-1:0] WA = '0;
   logic [DW-1:0] WD = '0;
   logic [NR*AW-1:0] RA = '0;
   logic [NR*DW-1:0] RD;
   logic INIT_BUSY, WR_DROP;

   reg_file_mp dut (
      .CLK(CLK), .RST_N(RST_N), .WE(WE), .WA(WA), .WD(WD), .CLR(CLR),
      .RA(RA), .RD(RD), .INIT_BUSY(INIT_BUSY), .WR_DROP(WR_DROP)
   );

   always #5 CLK = ~CLK;

   typedef struct {string tag; int sel; logic [31:0] exp;} item_t;
   item_t sb[$];
   int n_chk = 0, n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] sig(input int sel);
      case (sel)
         0: return RD[0 +: DW];
         1: return RD[DW +: DW];
         2: return {31'b0, INIT_BUSY};
         default: return {31'b0, WR_DROP};
      endcase
   endfunction

   task automatic push(input string tag, input int sel, input logic [31:0] exp);
      sb.push_back('{tag, sel, exp});
   endtask

   task automatic drain();
      item_t it;
      while (sb.size() > 0) begin
         it = sb.pop_front();
         check(it.tag, sig(it.sel), it.exp);
      end
   endtask

   task automatic step();
      @(negedge CLK);
      drain();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [31:0] init_val(input int a);
      return a == 2 ? 32'hF00 : a == 3 ? 32'h100 : 32'h0;
   endfunction

   task automatic walk(input string tag, input int we_at, input int drop_at);
      for (int i = 0; i < MD; i++) begin
         WE = (i == we_at);
         WA = 5'd7;
         WD = 32'hFFFF_FFFF;
         RA = {5'd3, 5'd2};
         push({tag, "_busy"}, 2, 1);
         push({tag, "_rd_zero"}, 0, 0);
         push({tag, "_drop"}, 3, {31'b0, i == drop_at});
         step();
      end
      WE = 1'b0;
      push({tag, "_busy_end"}, 2, 0);
      push({tag, "_drop_end"}, 3, 0);
      step();
   endtask

   task automatic dump(input string tag);
      for (int a = 0; a < MD; a++) begin
         RA = {AW'(a), AW'(a)};
         push($sformatf("%s_rd0_%0d", tag, a), 0, init_val(a));
         push($sformatf("%s_rd1_%0d", tag, a), 1, init_val(a));
         step();
      end
   endtask

   initial begin
      @(negedge CLK);
      push("rst_busy", 2, 1);
      push("rst_drop", 3, 0);
      push("rst_rd", 0, 0);
      drain();
      @(posedge CLK);
      #1 RST_N = 1'b1;
      walk("init", 10, 11);
      dump("init");
      // write then read on both ports
      WE = 1'b1; WA = 5'd5; WD = 32'hDEADBEEF; RA = {5'd5, 5'd5};
      push("wr_same", 0, BYP ? 32'hDEADBEEF : 32'h0);
      step();
      WE = 1'b0;
      push("wr_rd0", 0, 32'hDEADBEEF);
      push("wr_rd1", 1, 32'hDEADBEEF);
      push("wr_drop", 3, 0);
      step();
      // write to entry 0 discarded silently
      WE = 1'b1; WA = 5'd0; WD = 32'h1234; RA = '0;
      push("wa0_rd_same", 0, 0);
      step();
      WE = 1'b0;
      push("wa0_rd", 0, 0);
      push("wa0_drop", 3, 0);
      step();
      // bypass behaviour
      WE = 1'b1; WA = 5'd9; WD = 32'hA5A5A5A5; RA = {5'd9, 5'd9};
      push("byp_rd0", 0, BYP ? 32'hA5A5A5A5 : 32'h0);
      push("byp_rd1", 1, BYP ? 32'hA5A5A5A5 : 32'h0);
      step();
      WE = 1'b0;
      push("byp_after0", 0, 32'hA5A5A5A5);
      push("byp_after1", 1, 32'hA5A5A5A5);
      step();
      // soft clear with a colliding write
      WE = 1'b1; WA = 5'd4; WD = 32'h55;
      step();
      WE = 1'b0; RA = {5'd4, 5'd4};
      push("clr_pre", 0, 32'h55);
      step();
      CLR = 1'b1; WE = 1'b1; WA = 5'd6; WD = 32'h77;
      push("clr_idle", 2, 0);
      step();
      CLR = 1'b0; WE = 1'b0;
      walk("clr", -1, 0);
      dump("clr");
      // reset in the middle of a walk
      CLR = 1'b1;
      step();
      CLR = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i == 5) CLR = 1'b1;
         if (i == 6) CLR = 1'b0;
         push("mid_busy", 2, 1);
         step();
      end
      #2 RST_N = 1'b0;
      #1;
      push("mid_rst_busy", 2, 1);
      push("mid_rst_drop", 3, 0);
      drain();
      @(posedge CLK);
      #1 RST_N = 1'b1;
      walk("rst", -1, -1);
      dump("rst");
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
